// File: rtl/hicore_bypbuf_arb.sv
// Round-robin arbiter sharing one zero-latency valid/ready channel among NR requesters.
// The grant is held while the sink stalls, and priority rotates past each accepted beat.

module hicore_bypbuf_arb_lane #(
  parameter int IDW = 1,
  parameter int K   = 0
) (
  input  logic [IDW-1:0] ptr,
  input  logic [IDW-1:0] sel,
  input  logic           vld,
  input  logic           xfer_ok,
  output logic           hi,
  output logic           rdy
);
  // Requester sits in the upper half of the rotated scan (at or after ptr)
  assign hi  = vld & ({1'b0, ptr} <= (IDW+1)'(K));
  assign rdy = xfer_ok & (sel == IDW'(K));
endmodule

module hicore_bypbuf_arb #(
  parameter int NR  = 2,
  parameter int DW  = 32,
  parameter int IDW = $clog2(NR)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [NR-1:0]    i_vld,
  output logic [NR-1:0]    i_rdy,
  input  logic [NR*DW-1:0] i_dat,
  input  logic [NR-1:0]    i_cancel,
  output logic             o_vld,
  input  logic             o_rdy,
  output logic [DW-1:0]    o_dat,
  output logic             o_cancel,
  output logic [IDW-1:0]   o_id
);
  logic [IDW-1:0]          ptr, lock_id, sel, arb_id;
  logic                    lock, xfer_ok;
  logic [NR-1:0]           hi_vld, pick_hi, pick_any, pick;
  logic [NR:0][IDW-1:0]    acc;
  logic [NR-1:0][DW-1:0]   dat_a;

  assign dat_a = i_dat;

  genvar k;
  generate
    for (k = 0; k < NR; k++) begin : g_lane
      hicore_bypbuf_arb_lane #(.IDW(IDW), .K(k)) u_lane (
        .ptr     (ptr),
        .sel     (sel),
        .vld     (i_vld[k]),
        .xfer_ok (xfer_ok),
        .hi      (hi_vld[k]),
        .rdy     (i_rdy[k])
      );
      assign acc[k+1] = acc[k] | (pick[k] ? IDW'(k) : '0);
    end
  endgenerate

  // Lowest set bit at/after ptr wins; if none, wrap to the lowest set bit overall
  assign pick_hi  = hi_vld & (~hi_vld + NR'(1));
  assign pick_any = i_vld & (~i_vld + NR'(1));
  assign pick     = (|hi_vld) ? pick_hi : pick_any;
  assign acc[0]   = '0;
  assign arb_id   = acc[NR];

  assign sel      = lock ? lock_id : ((|i_vld) ? arb_id : ptr);
  assign o_vld    = ~flush & i_vld[sel];
  assign xfer_ok  = o_vld & o_rdy;
  assign o_dat    = dat_a[sel];
  assign o_cancel = i_cancel[sel];
  assign o_id     = sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= '0;
      lock    <= 1'b0;
      lock_id <= '0;
    end else if (flush) begin
      lock <= 1'b0;
    end else if (xfer_ok) begin
      ptr  <= (sel == IDW'(NR-1)) ? '0 : sel + IDW'(1);
      lock <= 1'b0;
    end else if (o_vld) begin
      lock    <= 1'b1;
      lock_id <= sel;
    end else if (lock) begin
      // locked requester withdrew its valid
      lock <= 1'b0;
    end
  end
endmodule

// File: tb/tb_hicore_bypbuf_arb.sv
// Directed bench for hicore_bypbuf_arb with NR=2 and NR=3 instances side by side.
module tb_hicore_bypbuf_arb;
  logic clk, rst_n;
  int pass_cnt, total_cnt;

  logic [1:0] v2, r2, c2;  logic [63:0] d2; logic f2, ov2, or2, oc2; logic [31:0] od2; logic [0:0] id2;
  logic [2:0] v3, r3, c3;  logic [95:0] d3; logic f3, ov3, or3, oc3; logic [31:0] od3; logic [1:0] id3;

  hicore_bypbuf_arb #(.NR(2), .DW(32)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .flush(f2), .i_vld(v2), .i_rdy(r2), .i_dat(d2), .i_cancel(c2),
    .o_vld(ov2), .o_rdy(or2), .o_dat(od2), .o_cancel(oc2), .o_id(id2));

  hicore_bypbuf_arb #(.NR(3), .DW(32)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .flush(f3), .i_vld(v3), .i_rdy(r3), .i_dat(d3), .i_cancel(c3),
    .o_vld(ov3), .o_rdy(or3), .o_dat(od3), .o_cancel(oc3), .o_id(id3));

  initial begin clk = 1'b0; forever #5 clk = ~clk; end

  task automatic cyc;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    #1; v2 = 2'b11; v3 = 3'b110;
    #1;
    total_cnt++; if (id2 !== 1'b0 || ov2 !== 1'b1 || r2 !== 2'b00) $display("FAIL reset_dut2 id=%0d vld=%0b rdy=%b exp id=0 vld=1 rdy=00", id2, ov2, r2); else pass_cnt++;
    total_cnt++; if (id3 !== 2'd1 || ov3 !== 1'b1) $display("FAIL reset_dut3 id=%0d vld=%0b exp id=1 vld=1", id3, ov3); else pass_cnt++;
    v2 = 2'b00; v3 = 3'b000;
    #1;
    total_cnt++; if (id2 !== 1'b0 || ov2 !== 1'b0 || id3 !== 2'd0 || ov3 !== 1'b0) $display("FAIL reset_idle id2=%0d ov2=%0b id3=%0d ov3=%0b exp 0 0 0 0", id2, ov2, id3, ov3); else pass_cnt++;
    cyc(); rst_n = 1'b1; cyc();
    v2 = 2'b10; #1;
    total_cnt++; if (id2 !== 1'b1 || ov2 !== 1'b1) $display("FAIL reset_lowest id=%0d vld=%0b exp id=1 vld=1", id2, ov2); else pass_cnt++;
    v2 = 2'b00;
  endtask

  task automatic test_rr2;
    logic [0:0] exp_id;
    v2 = 2'b11; or2 = 1'b1; d2 = {32'h2222_2222, 32'h1111_1111};
    for (int i = 0; i < 4; i++) begin
      exp_id = 1'(i % 2);
      #1;
      total_cnt++;
      if (id2 !== exp_id || r2 !== (exp_id ? 2'b10 : 2'b01) || od2 !== (exp_id ? 32'h2222_2222 : 32'h1111_1111))
        $display("FAIL rr2_beat%0d id=%0d rdy=%b dat=%h exp id=%0d", i, id2, r2, od2, exp_id);
      else pass_cnt++;
      cyc();
    end
    or2 = 1'b0; #1;
    total_cnt++; if (id2 !== 1'b0) $display("FAIL rr2_ptr_end id=%0d exp 0", id2); else pass_cnt++;
    v2 = 2'b00; cyc();
  endtask

  task automatic test_stall2;
    v2 = 2'b01; or2 = 1'b0; d2 = {32'hBBBB_0001, 32'hAAAA_0000};
    for (int c = 0; c < 4; c++) begin
      if (c == 1) v2 = 2'b11;
      if (c == 3) or2 = 1'b1;
      #1;
      total_cnt++;
      if (id2 !== 1'b0 || od2 !== 32'hAAAA_0000 || ov2 !== 1'b1 || r2 !== ((c == 3) ? 2'b01 : 2'b00))
        $display("FAIL stall2_c%0d id=%0d dat=%h vld=%0b rdy=%b exp id=0 dat=aaaa0000", c, id2, od2, ov2, r2);
      else pass_cnt++;
      cyc();
    end
    #1;
    total_cnt++; if (id2 !== 1'b1 || r2 !== 2'b10) $display("FAIL stall2_after id=%0d rdy=%b exp id=1 rdy=10", id2, r2); else pass_cnt++;
    v2 = 2'b00; or2 = 1'b0; cyc();
  endtask

  task automatic test_withdraw2;
    v2 = 2'b10; or2 = 1'b0; #1;
    total_cnt++; if (id2 !== 1'b1 || ov2 !== 1'b1) $display("FAIL withdraw_lock id=%0d vld=%0b exp id=1 vld=1", id2, ov2); else pass_cnt++;
    cyc();
    v2 = 2'b01; #1;
    total_cnt++; if (id2 !== 1'b1 || ov2 !== 1'b0) $display("FAIL withdraw_held id=%0d vld=%0b exp id=1 vld=0", id2, ov2); else pass_cnt++;
    cyc(); #1;
    total_cnt++; if (id2 !== 1'b0 || ov2 !== 1'b1) $display("FAIL withdraw_release id=%0d vld=%0b exp id=0 vld=1", id2, ov2); else pass_cnt++;
    v2 = 2'b00; cyc();
  endtask

  task automatic test_wrap3;
    logic [1:0] exp_id;
    v3 = 3'b101; or3 = 1'b1; d3 = '0;
    for (int i = 0; i < 4; i++) begin
      exp_id = (i % 2 == 0) ? 2'd0 : 2'd2;
      #1;
      total_cnt++;
      if (id3 !== exp_id || r3 !== (3'b001 << exp_id)) $display("FAIL wrap3_beat%0d id=%0d rdy=%b exp id=%0d", i, id3, r3, exp_id);
      else pass_cnt++;
      cyc();
    end
    or3 = 1'b0; v3 = 3'b111; #1;
    total_cnt++; if (id3 !== 2'd0) $display("FAIL wrap3_ptr id=%0d exp 0", id3); else pass_cnt++;
    v3 = 3'b000; cyc();
  endtask

  task automatic test_flush3;
    v3 = 3'b010; or3 = 1'b0; #1;
    total_cnt++; if (id3 !== 2'd1) $display("FAIL flush_pre id=%0d exp 1", id3); else pass_cnt++;
    cyc();
    v3 = 3'b111; #1;
    total_cnt++; if (id3 !== 2'd1 || r3 !== 3'b000) $display("FAIL flush_lock_hold id=%0d rdy=%b exp id=1 rdy=000", id3, r3); else pass_cnt++;
    f3 = 1'b1; or3 = 1'b1; #1;
    total_cnt++; if (ov3 !== 1'b0 || r3 !== 3'b000) $display("FAIL flush_out vld=%0b rdy=%b exp vld=0 rdy=000", ov3, r3); else pass_cnt++;
    cyc();
    f3 = 1'b0; or3 = 1'b0; #1;
    total_cnt++; if (id3 !== 2'd0 || ov3 !== 1'b1) $display("FAIL flush_after id=%0d vld=%0b exp id=0 vld=1", id3, ov3); else pass_cnt++;
    v3 = 3'b000; cyc();
  endtask

  task automatic test_cancel3;
    v3 = 3'b010; c3 = 3'b010; d3 = {32'h3333_3333, 32'hDEAD_BEEF, 32'h1111_1111}; or3 = 1'b1; #1;
    total_cnt++;
    if (oc3 !== 1'b1 || od3 !== 32'hDEAD_BEEF || r3 !== 3'b010 || ov3 !== 1'b1)
      $display("FAIL cancel_beat cancel=%0b dat=%h rdy=%b vld=%0b exp cancel=1 dat=deadbeef rdy=010 vld=1", oc3, od3, r3, ov3);
    else pass_cnt++;
    cyc();
    c3 = 3'b000; v3 = 3'b111; or3 = 1'b0; #1;
    total_cnt++; if (id3 !== 2'd2 || oc3 !== 1'b0) $display("FAIL cancel_ptr id=%0d cancel=%0b exp id=2 cancel=0", id3, oc3); else pass_cnt++;
    v3 = 3'b000; cyc();
  endtask

  task automatic test_reset_mid;
    v3 = 3'b111; or3 = 1'b0;
    cyc(); #1;
    total_cnt++; if (id3 !== 2'd2) $display("FAIL rstmid_lock id=%0d exp 2", id3); else pass_cnt++;
    rst_n = 1'b0; #1;
    total_cnt++; if (id3 !== 2'd0 || ov3 !== 1'b1) $display("FAIL rstmid_async id=%0d vld=%0b exp id=0 vld=1", id3, ov3); else pass_cnt++;
    or3 = 1'b1; #1;
    total_cnt++; if (r3 !== 3'b001) $display("FAIL rstmid_rdy rdy=%b exp 001", r3); else pass_cnt++;
    rst_n = 1'b1; #1;
    total_cnt++; if (id3 !== 2'd0 || r3 !== 3'b001) $display("FAIL rstmid_release id=%0d rdy=%b exp id=0 rdy=001", id3, r3); else pass_cnt++;
    cyc(); #1;
    total_cnt++; if (id3 !== 2'd1 || r3 !== 3'b010) $display("FAIL rstmid_next id=%0d rdy=%b exp id=1 rdy=010", id3, r3); else pass_cnt++;
    v3 = 3'b000; or3 = 1'b0;
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0;
    rst_n = 1'b0;
    v2 = '0; c2 = '0; d2 = '0; f2 = 1'b0; or2 = 1'b0;
    v3 = '0; c3 = '0; d3 = '0; f3 = 1'b0; or3 = 1'b0;
    test_reset();
    test_rr2();
    test_stall2();
    test_withdraw2();
    test_wrap3();
    test_flush3();
    test_cancel3();
    test_reset_mid();
    cyc();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
